fp_sqrt_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `fp_sqrt` unit between `N_REQ` independent requesters. Each requester offers a single-precision operand on a valid/ready channel and receives the result on its own response channel. The block grants one requester at a time, pulses the unit's `start`, and holds the operand stable for the whole operation. It waits for the unit's fixed latency and its `done` flag, captures the result and flags, and returns them to the granted requester. It sits between the FPU command decode and the single `fp_sqrt` instance.

---
 rtl/fp_sqrt_arbiter.sv | 136 +++++++++++++
 tb/tb_fp_sqrt_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_arbiter.sv
// Round-robin arbiter that time-shares one fp_sqrt unit between N_REQ requesters.
// Grants one operand, pulses start, waits out the fixed latency plus done, then returns the result.
module fp_sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 18,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_res,
    output logic                 rsp_overflow,
    output logic                 rsp_underflow,
    output logic                 rsp_exception,
    output logic                 sqrt_start,
    output logic [31:0]          sqrt_op,
    input  logic                 sqrt_done,
    input  logic [31:0]          sqrt_res,
    input  logic                 sqrt_overflow,
    input  logic                 sqrt_underflow,
    input  logic                 sqrt_exception,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    localparam int              CNT_W   = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            win_found;
    logic [31:0]     win_op;
    logic [31:0]     op_q;
    logic [CNT_W-1:0] cnt;

    // Round-robin search: first valid requester after the previous winner, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        win       = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(last) + i) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        win_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) win_op = req_op[32*i +: 32];
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready[win] = 1'b1;
                    state_nxt      = START;
                end
            end
            START: state_nxt = BUSY;
            BUSY: begin
                if (cnt == CNT_MAX && sqrt_done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[grant_id] = 1'b1;
                if (rsp_ready[grant_id]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter holds the number of cycles elapsed since the start pulse,
    // so it is zero during START and reaches LATENCY when the result is due.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state         <= IDLE;
            last          <= ID_W'(N_REQ - 1);
            grant_id      <= '0;
            op_q          <= '0;
            cnt           <= '0;
            rsp_res       <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_exception <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (win_found) begin
                        op_q     <= win_op;
                        grant_id <= win;
                        last     <= win;
                    end
                end
                START: begin
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                end
                BUSY: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (sqrt_done) begin
                        rsp_res       <= sqrt_res;
                        rsp_overflow  <= sqrt_overflow;
                        rsp_underflow <= sqrt_underflow;
                        rsp_exception <= sqrt_exception;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sqrt_start = (state == START);
    assign sqrt_op    = op_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Self-checking bench for fp_sqrt_arbiter: a behavioural sqrt unit stub plus a
// round-robin reference model driven by directed and randomized requests.
module tb_fp_sqrt_arbiter;

    localparam int N   = 4;
    localparam int L   = 18;
    localparam int IDW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_op;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_res;
    logic            rsp_overflow, rsp_underflow, rsp_exception;
    logic            sqrt_start;
    logic [31:0]     sqrt_op;
    logic            sqrt_done;
    logic [31:0]     sqrt_res;
    logic            sqrt_overflow, sqrt_underflow, sqrt_exception;
    logic            busy;
    logic [IDW-1:0]  grant_id;

    logic [31:0] ops [N];
    logic [N-1:0] keep;

    int tests = 0;
    int fails = 0;
    int last_m = N - 1;
    int late = 0;
    logic idle_hi = 1'b1;

    logic [31:0] sq_tab [logic [31:0]];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_ops
        assign req_op[32*g +: 32] = ops[g];
    end

    fp_sqrt_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow), .rsp_exception(rsp_exception),
        .sqrt_start(sqrt_start), .sqrt_op(sqrt_op), .sqrt_done(sqrt_done), .sqrt_res(sqrt_res),
        .sqrt_overflow(sqrt_overflow), .sqrt_underflow(sqrt_underflow), .sqrt_exception(sqrt_exception),
        .busy(busy), .grant_id(grant_id)
    );

    function automatic logic [31:0] i2f(int n);
        int p = 0;
        logic [31:0] m;
        for (int b = 0; b < 24; b++) if (n[b]) p = b;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] ref_res(logic [31:0] op);
        if (sq_tab.exists(op)) return sq_tab[op];
        return {op[15:0], op[31:16]} ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [2:0] ref_flags(logic [31:0] op);
        if (sq_tab.exists(op)) return 3'b000;
        return op[2:0];
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        if ($urandom % 2 == 0) begin
            k = int'($urandom_range(1, 200));
            return i2f(k * k);
        end
        return $urandom;
    endfunction

    // Sqrt unit stub: result valid L cycles after the start pulse (plus 'late').
    int          u_age = 0;
    logic        u_active = 1'b0;
    logic [31:0] u_res = '0;
    logic [2:0]  u_flags = '0;
    logic        u_ready;

    always @(posedge clk) begin
        if (sqrt_start) begin
            u_res    <= ref_res(sqrt_op);
            u_flags  <= ref_flags(sqrt_op);
            u_age    <= 1;
            u_active <= 1'b1;
        end else if (u_active && u_age < 100000) begin
            u_age <= u_age + 1;
        end
    end

    assign u_ready   = u_active && (u_age >= L + late);
    assign sqrt_done = idle_hi | u_ready;
    assign sqrt_res  = u_ready ? u_res : 32'hDEAD_BEEF;
    assign {sqrt_overflow, sqrt_underflow, sqrt_exception} = u_ready ? u_flags : 3'b111;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(string p);
        check({p, "_req_ready"}, 64'(req_ready), 64'(0));
        check({p, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({p, "_rsp_res"}, 64'(rsp_res), 64'(0));
        check({p, "_rsp_flags"}, 64'({rsp_overflow, rsp_underflow, rsp_exception}), 64'(0));
        check({p, "_sqrt_start"}, 64'(sqrt_start), 64'(0));
        check({p, "_sqrt_op"}, 64'(sqrt_op), 64'(0));
        check({p, "_busy"}, 64'(busy), 64'(0));
        check({p, "_grant_id"}, 64'(grant_id), 64'(0));
    endtask

    function automatic int model_winner();
        for (int i = 1; i <= N; i++)
            if (req_valid[(last_m + i) % N]) return (last_m + i) % N;
        return -1;
    endfunction

    // One complete transaction: grant, start, latency, response, return to IDLE.
    task automatic serve_one(output int w, output int waited, input int stall);
        logic [31:0] op;
        logic [31:0] held;
        int   k;
        logic stable;
        logic extra_start;
        logic hold_ok;
        #1;
        w = model_winner();
        waited = 0;
        while (req_ready == '0 && waited < 200) begin
            tick();
            waited++;
        end
        check("winner", 64'(req_ready), 64'(1) << w);
        if (req_ready == '0) return;
        op = ops[w];
        last_m = w;
        tick();
        if (keep[w]) ops[w] = rand_op();
        else req_valid[w] = 1'b0;
        #1;
        check("start_pulse", 64'(sqrt_start), 64'(1));
        check("grant_id", 64'(grant_id), 64'(w));
        check("busy_start", 64'(busy), 64'(1));
        check("ready_low_start", 64'(req_ready), 64'(0));
        k = 0;
        stable = 1'b1;
        extra_start = 1'b0;
        do begin
            tick();
            k++;
            if (sqrt_op !== op) stable = 1'b0;
            if (sqrt_start) extra_start = 1'b1;
        end while (rsp_valid == '0 && k < 200);
        check("latency", 64'(k), 64'(L + 1 + late));
        check("op_stable", 64'(stable), 64'(1));
        check("start_once", 64'(extra_start), 64'(0));
        check("rsp_valid", 64'(rsp_valid), 64'(1) << w);
        check("rsp_res", 64'(rsp_res), 64'(ref_res(op)));
        check("rsp_flags", 64'({rsp_overflow, rsp_underflow, rsp_exception}), 64'(ref_flags(op)));
        if (stall > 0) begin
            held = rsp_res;
            hold_ok = 1'b1;
            rsp_ready = ~(N'(1) << w);
            repeat (stall) begin
                tick();
                if (rsp_res !== held || rsp_valid !== (N'(1) << w) || req_ready !== '0)
                    hold_ok = 1'b0;
            end
            check("stall_hold", 64'(hold_ok), 64'(1));
            rsp_ready = '1;
        end
        tick();
        check("busy_idle", 64'(busy), 64'(0));
        check("rsp_clear", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        int w, waited, k;
        logic quiet;
        for (int i = 1; i <= 200; i++) sq_tab[i2f(i * i)] = i2f(i);
        req_valid = '0;
        rsp_ready = '1;
        keep = '0;
        for (int i = 0; i < N; i++) ops[i] = '0;
        rst = 1'b0;
        repeat (2) tick();
        check_reset("reset");
        rst = 1'b1;
        tick();

        // Single request from requester 2 (4.0 -> 2.0).
        ops[2] = 32'h4080_0000;
        req_valid[2] = 1'b1;
        serve_one(w, waited, 0);

        // All four at once after reset: order 0,1,2,3.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        last_m = N - 1;
        ops[0] = 32'h4180_0000;
        ops[1] = 32'h4110_0000;
        ops[2] = 32'h4080_0000;
        ops[3] = 32'h3F80_0000;
        req_valid = '1;
        for (int i = 0; i < N; i++) serve_one(w, waited, 0);

        // Fairness: 0 and 1 request continuously.
        keep = 4'b0011;
        ops[0] = rand_op();
        ops[1] = rand_op();
        req_valid = 4'b0011;
        repeat (6) serve_one(w, waited, 0);
        keep = '0;
        serve_one(w, waited, 0);

        // Backpressure on requester 1 while requester 3 waits.
        ops[1] = rand_op();
        ops[3] = rand_op();
        req_valid = 4'b1010;
        serve_one(w, waited, 20);
        serve_one(w, waited, 0);
        check("bp_next_grant_wait", 64'(waited), 64'(0));

        // Late done from the unit.
        idle_hi = 1'b0;
        late = 5;
        ops[0] = 32'h4110_0000;
        req_valid[0] = 1'b1;
        serve_one(w, waited, 0);
        late = 0;
        idle_hi = 1'b1;

        // Reset while BUSY at counter 7.
        ops[2] = 32'h4180_0000;
        req_valid[2] = 1'b1;
        #1;
        k = 0;
        while (req_ready == '0 && k < 50) begin
            tick();
            k++;
        end
        check("rst_mid_grant", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = '0;
        repeat (7) tick();
        rst = 1'b0;
        tick();
        check_reset("rst_mid");
        rst = 1'b1;
        last_m = N - 1;
        quiet = 1'b1;
        repeat (L + 10) begin
            tick();
            if (rsp_valid !== '0 || busy !== 1'b0) quiet = 1'b1 & 1'b0;
        end
        check("rst_mid_no_rsp", 64'(quiet), 64'(1));
        ops[0] = rand_op();
        ops[3] = rand_op();
        req_valid = 4'b1001;
        serve_one(w, waited, 0);
        serve_one(w, waited, 0);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 2 == 0)) begin
                    ops[i] = rand_op();
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                k = int'($urandom_range(0, N - 1));
                ops[k] = rand_op();
                req_valid[k] = 1'b1;
            end
            late = int'($urandom % 3);
            idle_hi = (late == 0);
            serve_one(w, waited, ($urandom % 4 == 0) ? int'($urandom_range(1, 5)) : 0);
        end
        late = 0;
        idle_hi = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
